// File: rtl/out_channel_buffer.sv
// rtl/out_channel_buffer.sv - out channel word buffer with program-completion tracking
//
// Captures each word the program executor emits, buffers up to NOut words in a
// circular array, and drains them oldest-first over a valid/ready stream.
// Once the executor reports finished and the buffer has drained, done is raised
// and held until reset.
//
// Optional build macro: OUT_CHANNEL_WRAP_EN
//   defined   - a put into a full buffer (no pop) overwrites the oldest word
//   undefined - a put into a full buffer (no pop) is dropped
//   Both cases set overflow_o (sticky).
//
// Ports:
//   clock_i       single clock, posedge
//   reset_i       synchronous, active-high; wins over all inputs
//   put_i         executor writes put_data_i this cycle
//   put_data_i    word written by the out instruction
//   finished_i    executor program finished (level)
//   out_valid_o   out_data_o holds the oldest buffered word
//   out_data_o    head word, registered, stable while stalled
//   out_ready_i   consumer accepts head when out_valid_o && out_ready_i
//   count_o       words currently buffered, 0..NOut
//   full_o        count_o == NOut
//   overflow_o    sticky: a put hit a full buffer
//   late_write_o  sticky: a put arrived after finished was seen
//   done_o        finished seen and buffer drained
module out_channel_buffer #(
  parameter int MemoryElementWidth = 12,
  parameter int NOut               = 100,
  localparam int CW                = $clog2(NOut + 1)
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic                          put_i,
  input  logic [MemoryElementWidth-1:0] put_data_i,
  input  logic                          finished_i,
  output logic                          out_valid_o,
  output logic [MemoryElementWidth-1:0] out_data_o,
  input  logic                          out_ready_i,
  output logic [CW-1:0]                 count_o,
  output logic                          full_o,
  output logic                          overflow_o,
  output logic                          late_write_o,
  output logic                          done_o
);

  localparam int PW = $clog2(NOut);

  typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;

  state_t                        state_q, state_d;
  logic [MemoryElementWidth-1:0] mem_q [NOut];
  logic [PW-1:0]                 rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]                 wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]                 count_q, count_d;
  logic                          out_valid_q, out_valid_d;
  logic [MemoryElementWidth-1:0] out_data_q, out_data_d;
  logic                          overflow_q, overflow_d;
  logic                          late_write_q, late_write_d;

  logic pop;
  logic full;
  logic put_ok;
  logic write;
  logic advance;

  // Pointers wrap at NOut, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(NOut - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    pop        = out_valid_q && out_ready_i;
    full       = (count_q == CW'(NOut));
    put_ok     = put_i && (state_q == RUN);
    write      = 1'b0;
    advance    = pop;
    overflow_d = overflow_q;

    if (put_ok) begin
      if (full && !pop) begin
`ifdef OUT_CHANNEL_WRAP_EN
        // Overwrite the oldest word: the head moves on with the tail.
        write   = 1'b1;
        advance = 1'b1;
`endif
        overflow_d = 1'b1;
      end else begin
        write = 1'b1;
      end
    end

    count_d = count_q;
    if (write && !advance) begin
      count_d = count_q + 1'b1;
    end else if (!write && advance) begin
      count_d = count_q - 1'b1;
    end

    rd_ptr_d = advance ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = write   ? ptr_inc(wr_ptr_q) : wr_ptr_q;

    // The output register only presents words already in the array before
    // this edge; a word written this edge becomes visible one edge later.
    out_valid_d = advance ? (count_q > CW'(1)) : (count_q != '0);
    out_data_d  = out_valid_d ? mem_q[rd_ptr_d] : out_data_q;

    late_write_d = late_write_q | (put_i && (state_q != RUN));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (finished_i) state_d = FLUSH;
      FLUSH:   if (count_q == '0) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= RUN;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      overflow_q   <= 1'b0;
      late_write_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      overflow_q   <= overflow_d;
      late_write_q <= late_write_d;
    end
  end

  // Array contents need no reset; the pointers and count define what is live.
  always_ff @(posedge clock_i) begin
    if (write) begin
      mem_q[wr_ptr_q] <= put_data_i;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_data_o   = out_data_q;
  assign count_o      = count_q;
  assign full_o       = full;
  assign overflow_o   = overflow_q;
  assign late_write_o = late_write_q;
  assign done_o       = (state_q == DONE);

endmodule
